irq_arbiter: RTL
================

// Module: irq_arbiter
// PURPOSE
//  Interrupt scheduler sitting beside csr_file: arbitrates pending M/S interrupt lines against mie,
//  mideleg, mstatus.MIE/SIE and current privilege, picks one winner by fixed RISC-V priority, and
//  sequences its delivery to the trap logic via a req/ack handshake, then holds off re-arbitration.
// PARAMETERS
//  HOLD_CYCLES  2   cycles after ack before re-arbitration (lets mstatus/mip updates settle)
//  REQ_TIMEOUT  64  cycles irq_req may stay unacked before being withdrawn and re-arbitrated
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  stall        in   1   pipeline stalled (STALL_MMU); freezes the FSM and the counters
//  msip/mtip/meip in 1   machine software/timer/external pending lines
//  ssip/stip/seip in 1   supervisor pending lines (from mip)
//  mie          in   32  mie CSR
//  mideleg      in   32  mideleg CSR
//  mstatus_mie  in   1   mstatus.MIE
//  mstatus_sie  in   1   mstatus.SIE
//  priv         in   2   current privilege (00 U, 01 S, 11 M)
//  exc_taken    in   1   synchronous exception entering trap this cycle (has priority)
//  trap_ack     in   1   trap logic accepted irq_req (one-cycle pulse)
//  irq_req      out  1   interrupt trap request
//  irq_cause    out  5   exception code of the winner (mcause/scause low bits; MSB=1 added by CSR)
//  irq_to_s     out  1   winner is delegated -> trap into S-mode
//  irq_timeout  out  1   one-cycle pulse when a request is withdrawn on timeout
//  wfi_wake     out  1   any (pending & mie) bit set, ignoring global enables and delegation
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, counters 0. rst mid-request drops irq_req on the next edge.
//  - Candidates: bit i eligible if pip[i] & mie[i]. Non-delegated (mideleg[i]=0): enabled if
//    priv<M, or priv==M & mstatus_mie. Delegated: enabled if priv==U, or priv==S & mstatus_sie;
//    never enabled when priv==M.
//  - Priority (highest first): MEI 11, MSI 3, MTI 7, SEI 9, SSI 1, STI 5. Combinational.
//  - FSM states IDLE, REQ, HOLD:
//    IDLE: if winner exists & !stall & !exc_taken -> REQ; latch irq_cause/irq_to_s that edge.
//    REQ : irq_req=1, cause frozen (no re-arbitration even if a higher line rises).
//          trap_ack -> HOLD, irq_req 0 next cycle. exc_taken (without ack) -> IDLE, no ack
//          consumed. Timeout counter increments on each non-stalled cycle; reaching REQ_TIMEOUT
//          -> IDLE, irq_timeout pulses 1 cycle. If trap_ack and exc_taken coincide, ack wins.
//    HOLD: counts HOLD_CYCLES non-stalled cycles, then IDLE. trap_ack ignored here.
//  - Latency: line asserted at edge N (enabled) -> irq_req high after edge N+1 (+2 sync stages
//    when IRQ_SYNC_EN). Back-to-back interrupts separated by >= HOLD_CYCLES+1 cycles.
//  - Candidate vanishing while in REQ does not cancel the request; trap logic re-checks.
//  - stall: FSM holds state, counters frozen, outputs held.
//  - wfi_wake is combinational from (synchronised) lines and mie only.
// CONFIGURATION
//  IRQ_SYNC_EN defined: meip and seip (asynchronous UART/PLIC sources) pass a 2-flop
//  synchroniser (reset 0) before arbitration and wfi_wake. Undefined: used directly, no added
//  latency. Other lines are always sampled raw.
// STRUCTURE
//  - irq_defs.v (`include, alongside csr_defs.v): cause codes IRQ_MSI/MTI/MEI/SSI/STI/SEI,
//    FSM state encodings, PRIV_U/S/M constants.
//  - Sub-module irq_prio_enc: combinational eligible-mask -> {valid, cause, to_s} encoder.
//  - Top: sync flops, FSM, hold and timeout counters sized $clog2 of their parameter.
// TESTING
//  - priv=M, MIE=1, mie=0x888, mtip=1 then meip=1 same cycle -> irq_req, irq_cause=11, irq_to_s=0.
//  - priv=S, SIE=1, mideleg[5]=1, mie[5]=1, stip=1 -> irq_cause=5, irq_to_s=1; same at priv=M -> no req.
//  - REQ held, no ack for 64 cycles -> irq_timeout pulse, irq_req low, re-request next cycle.
//  - trap_ack in REQ -> irq_req low next cycle, no new req for 2 cycles despite msip still high.
//  - exc_taken in REQ -> IDLE without ack; stall=1 for 10 cycles freezes timeout count.
//  - MIE=0, priv=M, mie[7]=1, mtip=1 -> irq_req=0, wfi_wake=1.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: cause codes, privilege encodings and FSM states shared by the interrupt arbiter
package irq_arbiter_pkg;

    localparam logic [4:0] IRQ_SSI = 5'd1;
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_STI = 5'd5;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_SEI = 5'd9;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: interrupt request/ack handshake between the arbiter (master) and trap logic (slave)
interface irq_arbiter_if;

    logic       irq_req;
    logic [4:0] irq_cause;
    logic       irq_to_s;
    logic       irq_timeout;
    logic       trap_ack;
    logic       exc_taken;

    modport master (output irq_req, irq_cause, irq_to_s, irq_timeout, input trap_ack, exc_taken);
    modport slave  (input irq_req, irq_cause, irq_to_s, irq_timeout, output trap_ack, exc_taken);

endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// irq_arbiter_prio_enc: fixed RISC-V priority pick (MEI, MSI, MTI, SEI, SSI, STI) over enabled candidates
module irq_arbiter_prio_enc
    import irq_arbiter_pkg::*;
(
    input  logic [31:0] cand,
    input  logic [31:0] cand_s,
    output logic        valid,
    output logic [4:0]  cause,
    output logic        to_s
);

    // highest-priority candidate wins; to_s follows the winner's delegation
    always_comb begin
        cause = cand[IRQ_MEI] ? IRQ_MEI :
                cand[IRQ_MSI] ? IRQ_MSI :
                cand[IRQ_MTI] ? IRQ_MTI :
                cand[IRQ_SEI] ? IRQ_SEI :
                cand[IRQ_SSI] ? IRQ_SSI : IRQ_STI;
        valid = |cand;
        to_s  = |(cand_s & (32'd1 << cause));
    end

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: arbitrates pending interrupts and sequences req/ack delivery to trap logic; IRQ_SYNC_EN adds 2-flop sync on meip/seip
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        msip,
    input  logic        mtip,
    input  logic        meip,
    input  logic        ssip,
    input  logic        stip,
    input  logic        seip,
    input  logic [31:0] mie,
    input  logic [31:0] mideleg,
    input  logic        mstatus_mie,
    input  logic        mstatus_sie,
    input  logic [1:0]  priv,
    irq_arbiter_if.master bus,
    output logic        wfi_wake
);

    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = REQ_TIMEOUT > 1 ? $clog2(REQ_TIMEOUT) : 1;

    logic          meip_s, seip_s;
    logic [31:0]   pend, act, cand, cand_s;
    logic          m_en, s_en;
    logic          win_valid, win_to_s;
    logic [4:0]    win_cause;
    state_t        state;
    logic [HW-1:0] hcnt;
    logic [TW-1:0] tcnt;

`ifdef IRQ_SYNC_EN
    logic [1:0] meip_q, seip_q;

    // two-flop synchronisers for the asynchronous PLIC/UART lines
    always_ff @(posedge clk) begin
        if (rst) begin
            meip_q <= '0;
            seip_q <= '0;
        end else begin
            meip_q <= {meip_q[0], meip};
            seip_q <= {seip_q[0], seip};
        end
    end

    assign meip_s = meip_q[1];
    assign seip_s = seip_q[1];
`else
    assign meip_s = meip;
    assign seip_s = seip;
`endif

    // mip image, per-privilege global enables and the enabled candidate sets
    always_comb begin
        pend   = {20'b0, meip_s, 1'b0, seip_s, 1'b0, mtip, 1'b0, stip, 1'b0, msip, 1'b0, ssip, 1'b0};
        act    = pend & mie;
        m_en   = priv != PRIV_M || mstatus_mie;
        s_en   = priv == PRIV_U || (priv == PRIV_S && mstatus_sie);
        cand_s = act & mideleg & {32{s_en}};
        cand   = (act & ~mideleg & {32{m_en}}) | cand_s;
        wfi_wake = |act;
    end

    irq_arbiter_prio_enc u_enc (
        .cand   (cand),
        .cand_s (cand_s),
        .valid  (win_valid),
        .cause  (win_cause),
        .to_s   (win_to_s)
    );

    // delivery FSM: latch a winner, hold it until ack/exception/timeout, then back off
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            bus.irq_req     <= 1'b0;
            bus.irq_cause   <= '0;
            bus.irq_to_s    <= 1'b0;
            bus.irq_timeout <= 1'b0;
            hcnt            <= '0;
            tcnt            <= '0;
        end else if (!stall) begin
            bus.irq_timeout <= 1'b0;
            case (state)
                ST_IDLE: if (win_valid && !bus.exc_taken) begin
                    state         <= ST_REQ;
                    bus.irq_req   <= 1'b1;
                    bus.irq_cause <= win_cause;
                    bus.irq_to_s  <= win_to_s;
                    tcnt          <= '0;
                end
                ST_REQ: if (bus.trap_ack) begin
                    state       <= ST_HOLD;
                    bus.irq_req <= 1'b0;
                    hcnt        <= '0;
                end else if (bus.exc_taken) begin
                    state       <= ST_IDLE;
                    bus.irq_req <= 1'b0;
                end else if (tcnt == TW'(REQ_TIMEOUT - 1)) begin
                    state           <= ST_IDLE;
                    bus.irq_req     <= 1'b0;
                    bus.irq_timeout <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                ST_HOLD: if (hcnt == HW'(HOLD_CYCLES - 1)) state <= ST_IDLE;
                         else hcnt <= hcnt + 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
